mem_word_assembler: RTL and testbench
=====================================

MEM_WORD_ASSEMBLER -- requirements
Module: mem_word_assembler

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 0: 0 = first byte read lands in word_data[7:0]; 1 = first byte lands in word_data[31:24].
REQ-002 SHALL have parameter CNT_W, default 16: width of word_count.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_empty  input  1  empty flag from the upstream byte memory.
REQ-006 SHALL have port mem_data  input  8  registered read data from the upstream byte memory.
REQ-007 SHALL have port mem_rd_en  output  1  one-cycle read strobe to the upstream byte memory.
REQ-008 SHALL have port flush  input  1  request to emit a partially filled word.
REQ-009 SHALL have port word_data  output  32  assembled word.
REQ-010 SHALL have port word_bytes  output  3  number of valid bytes in word_data, range 1..4.
REQ-011 SHALL have port word_valid  output  1  word_data and word_bytes are valid.
REQ-012 SHALL have port word_ready  input  1  consumer accepts the word.
REQ-013 SHALL have port word_count  output  CNT_W  count of words accepted; saturates at all-ones.

Function
REQ-014 SHALL implement FSM states IDLE, READ, CAPTURE and HOLD; a 2-bit byte index (byte_idx) and a 32-bit assembly buffer.
REQ-015 IDLE transitions SHALL be:
  - mem_empty=0 -> READ.
  - else flush=1 and byte_idx!=0 -> HOLD with word_bytes=byte_idx.
  - else stay in IDLE.
  - Emptiness SHALL have priority over flush.
REQ-016 READ SHALL assert mem_rd_en for exactly that one cycle, then go unconditionally to CAPTURE.
REQ-017 mem_rd_en SHALL decode only from the registered state, with no combinational path from any input.
REQ-018 CAPTURE SHALL:
  - write mem_data into lane byte_idx, with lane order set by BIG_ENDIAN;
  - increment byte_idx;
  - go to HOLD with word_bytes=4 if byte_idx was 3, else to IDLE.
REQ-019 Byte lanes never written in the current word SHALL read as 0x00.
REQ-020 HOLD SHALL hold word_valid=1 with word_data and word_bytes stable until the cycle word_ready=1.
REQ-021 A HOLD cycle with word_ready=1 SHALL:
  - complete the transfer;
  - clear the buffer and byte_idx to 0 and word_bytes to 0;
  - increment word_count, saturating;
  - return to IDLE.
REQ-022 word_valid SHALL be 0 in every state except HOLD.
REQ-023 flush SHALL be ignored in READ, CAPTURE and HOLD, and in IDLE when byte_idx=0; flush is level-sampled, with no pulse memory.
REQ-024 The block SHALL never issue mem_rd_en while in HOLD (backpressure stalls reads).
REQ-025 Minimum spacing between consecutive mem_rd_en pulses SHALL be 3 cycles (READ, CAPTURE, IDLE).
REQ-026 A full word SHALL take at least 12 cycles plus the handshake cycle.
REQ-027 word_count SHALL wrap-protect: at 2^CNT_W-1 it holds its value.

Reset
REQ-028 rst=0 SHALL, asynchronously:
  - force state to IDLE;
  - force mem_rd_en=0, word_valid=0, word_data=0, word_bytes=0, word_count=0 and byte_idx=0.
REQ-029 Reset during READ or CAPTURE SHALL discard the partial word, and the read byte is lost.
REQ-030 After rst deasserts, the first mem_rd_en SHALL occur no earlier than 2 rising edges later.

Verification
REQ-031 Bytes 0x11,0x22,0x33,0x44 available, BIG_ENDIAN=0, word_ready=1 -> word_data=0x44332211, word_bytes=4, word_count=1.
REQ-032 The same bytes with BIG_ENDIAN=1 -> word_data=0x11223344.
REQ-033 Bytes 0xAA,0xBB, then mem_empty=1 and a flush pulse in IDLE -> word_data=0x0000BBAA, word_bytes=2; a second flush with byte_idx=0 -> no word_valid.
REQ-034 word_ready held 0 for 20 cycles in HOLD with mem_empty=0 -> word_valid and word_data stable, and mem_rd_en=0 throughout.
REQ-035 rst=0 asserted mid-CAPTURE after 3 bytes -> all outputs 0 immediately; the next word starts in lane 0.
REQ-036 CNT_W=2, 5 words transferred -> word_count=3.

Source files
------------

// File: rtl/mem_word_assembler.sv
// mem_word_assembler: pulls bytes one at a time from an upstream byte memory,
// packs them into a 32-bit word and hands the word to a consumer with a
// valid/ready handshake. A flush request emits a partially filled word.
// Each byte costs three cycles (READ, CAPTURE, IDLE), so reads are spaced at
// least three cycles apart and no read is issued while a word waits in HOLD.
module mem_word_assembler #(
    parameter int unsigned BIG_ENDIAN = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_empty,
    input  logic [7:0]       mem_data,
    output logic             mem_rd_en,
    input  logic             flush,
    output logic [31:0]      word_data,
    output logic [2:0]       word_bytes,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] READ    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,    state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      buf_q,      buf_d;
    logic [2:0]       bytes_q,    bytes_d;
    logic [CNT_W-1:0] count_q,    count_d;
    // armed_q delays the first read by one extra edge after reset release,
    // giving the upstream memory a settled cycle before it is strobed.
    logic             armed_q,    armed_d;
    logic [1:0]       lane_s;

    // Map the byte index onto a physical lane according to the byte order.
    always_comb begin
        lane_s = byte_idx_q;
        if (BIG_ENDIAN != 0) begin
            lane_s = 2'd3 - byte_idx_q;
        end else begin
            lane_s = byte_idx_q;
        end
    end

    // Next-state logic for the FSM, byte index, assembly buffer and counter.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        bytes_d    = bytes_q;
        count_d    = count_q;
        armed_d    = 1'b1;
        case (state_q)
            IDLE: begin
                // Pending data wins over a flush request.
                if (!armed_q) begin
                    state_d = IDLE;
                end else if (!mem_empty) begin
                    state_d = READ;
                end else if (flush && (byte_idx_q != 2'd0)) begin
                    state_d = HOLD;
                    bytes_d = {1'b0, byte_idx_q};
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // mem_data is the registered response to the READ strobe.
                buf_d[{lane_s, 3'b000} +: 8] = mem_data;
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    state_d = HOLD;
                    bytes_d = 3'd4;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    state_d    = IDLE;
                    buf_d      = 32'h0000_0000;
                    byte_idx_d = 2'd0;
                    bytes_d    = 3'd0;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_ONE;
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            buf_q      <= 32'h0000_0000;
            bytes_q    <= 3'd0;
            count_q    <= {CNT_W{1'b0}};
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            bytes_q    <= bytes_d;
            count_q    <= count_d;
            armed_q    <= armed_d;
        end
    end

    // Outputs decode only from registers; no input reaches them combinationally.
    assign mem_rd_en  = (state_q == READ);
    assign word_valid = (state_q == HOLD);
    assign word_data  = buf_q;
    assign word_bytes = bytes_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_mem_word_assembler.sv
// Directed testbench for mem_word_assembler. Three instances share stimulus:
// little-endian/16-bit count, big-endian, and little-endian with 2-bit count.
// A small byte-memory model feeds all three from one table.
module tb_mem_word_assembler;

    logic        clk;
    logic        rst;
    logic        mem_empty;
    logic [7:0]  mem_data;
    logic        flush;
    logic        word_ready;

    logic        rd_en0, rd_en1, rd_en2;
    logic [31:0] data0, data1, data2;
    logic [2:0]  bytes0, bytes1, bytes2;
    logic        valid0, valid1, valid2;
    logic [15:0] count0, count1;
    logic [1:0]  count2;

    int n_checks;
    int n_errors;

    logic [7:0] mem_arr [0:255];
    int         wr_ptr;
    int         rd_ptr;

    mem_word_assembler #(.BIG_ENDIAN(0), .CNT_W(16)) dut_le (
        .clk(clk), .rst(rst), .mem_empty(mem_empty), .mem_data(mem_data),
        .mem_rd_en(rd_en0), .flush(flush), .word_data(data0), .word_bytes(bytes0),
        .word_valid(valid0), .word_ready(word_ready), .word_count(count0));

    mem_word_assembler #(.BIG_ENDIAN(1), .CNT_W(16)) dut_be (
        .clk(clk), .rst(rst), .mem_empty(mem_empty), .mem_data(mem_data),
        .mem_rd_en(rd_en1), .flush(flush), .word_data(data1), .word_bytes(bytes1),
        .word_valid(valid1), .word_ready(word_ready), .word_count(count1));

    mem_word_assembler #(.BIG_ENDIAN(0), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .mem_empty(mem_empty), .mem_data(mem_data),
        .mem_rd_en(rd_en2), .flush(flush), .word_data(data2), .word_bytes(bytes2),
        .word_valid(valid2), .word_ready(word_ready), .word_count(count2));

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory model: registered read data, popped on the read strobe.
    assign mem_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (rd_en0 && (rd_ptr != wr_ptr)) begin
            mem_data <= mem_arr[rd_ptr[7:0]];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem_arr[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Advance until word_valid is seen on the reference instance, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid0 && cyc < 60) begin
            step();
            cyc = cyc + 1;
        end
        if (!valid0) check("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    int cyc;
    int pulses;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        wr_ptr     = 0;
        rd_ptr     = 0;
        mem_data   = 8'h00;
        rst        = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;
        #12;
        // Reset state
        check("rst_rd_en", {31'd0, rd_en0}, 32'd0);
        check("rst_valid", {31'd0, valid0}, 32'd0);
        check("rst_data", data0, 32'd0);
        check("rst_bytes", {29'd0, bytes0}, 32'd0);
        check("rst_count", {16'd0, count0}, 32'd0);

        // Full word, first read two edges after reset release
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        word_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        step();
        check("first_rd_edge1", {31'd0, rd_en0}, 32'd0);
        step();
        check("first_rd_edge2", {31'd0, rd_en0}, 32'd1);
        wait_valid(cyc);
        check("full_latency", cyc, 32'd11);
        check("le_data", data0, 32'h4433_2211);
        check("le_bytes", {29'd0, bytes0}, 32'd4);
        check("be_data", data1, 32'h1122_3344);
        step();
        check("count_after_1", {16'd0, count0}, 32'd1);
        check("valid_after_hs", {31'd0, valid0}, 32'd0);
        check("data_cleared", data0, 32'd0);
        check("bytes_cleared", {29'd0, bytes0}, 32'd0);

        // Partial word with flush
        word_ready = 1'b0;
        push(8'hAA); push(8'hBB);
        repeat (10) step();
        check("partial_no_valid", {31'd0, valid0}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", {31'd0, valid0}, 32'd1);
        check("flush_le_data", data0, 32'h0000_BBAA);
        check("flush_le_bytes", {29'd0, bytes0}, 32'd2);
        check("flush_be_data", data1, 32'hAABB_0000);
        check("flush_be_bytes", {29'd0, bytes1}, 32'd2);
        repeat (3) begin
            step();
            check("flush_hold_valid", {31'd0, valid0}, 32'd1);
            check("flush_hold_data", data0, 32'h0000_BBAA);
        end
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        check("count_after_2", {16'd0, count0}, 32'd2);
        flush = 1'b1;
        repeat (3) begin
            step();
            check("empty_flush_ignored", {31'd0, valid0}, 32'd0);
            check("empty_flush_no_rd", {31'd0, rd_en0}, 32'd0);
        end
        flush = 1'b0;

        // Backpressure: 20 cycles in HOLD with data pending
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        wait_valid(cyc);
        check("stall_data", data0, 32'h0403_0201);
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall_valid", {31'd0, valid0}, 32'd1);
            check("stall_data_hold", data0, 32'h0403_0201);
            check("stall_bytes_hold", {29'd0, bytes0}, 32'd4);
            check("stall_no_rd", {31'd0, rd_en0}, 32'd0);
        end
        word_ready = 1'b1;
        step();
        check("count_after_3", {16'd0, count0}, 32'd3);
        check("c2_after_3", {30'd0, count2}, 32'd3);
        wait_valid(cyc);
        check("word4_data", data0, 32'h0807_0605);
        step();
        check("count_after_4", {16'd0, count0}, 32'd4);
        check("c2_after_4", {30'd0, count2}, 32'd3);
        push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
        wait_valid(cyc);
        check("word5_data", data0, 32'h8D7C_6B5A);
        step();
        check("count_after_5", {16'd0, count0}, 32'd5);
        check("c2_saturated", {30'd0, count2}, 32'd3);

        // Reset in the middle of the third byte's CAPTURE
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        pulses = 0;
        cyc = 0;
        while (pulses < 3 && cyc < 60) begin
            step();
            cyc = cyc + 1;
            if (rd_en0) pulses = pulses + 1;
        end
        check("rst_test_pulses", pulses, 32'd3);
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_rd_en", {31'd0, rd_en0}, 32'd0);
        check("mid_rst_valid", {31'd0, valid0}, 32'd0);
        check("mid_rst_data", data0, 32'd0);
        check("mid_rst_bytes", {29'd0, bytes0}, 32'd0);
        check("mid_rst_count", {16'd0, count0}, 32'd0);
        check("mid_rst_c2", {30'd0, count2}, 32'd0);
        wr_ptr = rd_ptr;
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        @(negedge clk);
        rst = 1'b1;
        wait_valid(cyc);
        check("post_rst_le_data", data0, 32'hE4E3_E2E1);
        check("post_rst_be_data", data1, 32'hE1E2_E3E4);
        step();
        check("post_rst_count", {16'd0, count0}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
